// File: rtl/da_idct_pkg.sv
// Shared constants, state encoding and output rounding for the 4-point DA inverse DCT.
// Coefficients are the orthonormal 4-point DCT basis values in Q.CF fixed point.
package da_idct_pkg;

  localparam int unsigned CF = 10;
  localparam int C_A = 512;
  localparam int C_B = 669;
  localparam int C_C = 277;
  // Width of one LUT entry; worst-case |sum| is 1970.
  localparam int unsigned LW = 12;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  // Round half up, drop cf fraction bits, then clamp to a signed dw-bit range.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input int unsigned cf,
                                                   input int unsigned dw);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (acc + (64'sd1 <<< (cf - 1))) >>> cf;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/da_idct4_lut.sv
// Distributed-arithmetic LUT: for one bit-slice {Y0,Y1,Y2,Y3} returns the partial sum of
// each output row's coefficients. Y0 drives the address MSB.
module da_idct4_lut
  import da_idct_pkg::*;
(
  input  logic [3:0]           addr_i,
  output logic signed [LW-1:0] lut0_o,
  output logic signed [LW-1:0] lut1_o,
  output logic signed [LW-1:0] lut2_o,
  output logic signed [LW-1:0] lut3_o
);

  int s0;
  int s1;
  int s2;
  int s3;

  // Rows: x0=[a,b,a,c]  x1=[a,c,-a,-b]  x2=[a,-c,-a,b]  x3=[a,-b,a,-c]
  always_comb begin
    s0 = 0;
    s1 = 0;
    s2 = 0;
    s3 = 0;
    if (addr_i[3]) begin
      s0 += C_A;
      s1 += C_A;
      s2 += C_A;
      s3 += C_A;
    end
    if (addr_i[2]) begin
      s0 += C_B;
      s1 += C_C;
      s2 -= C_C;
      s3 -= C_B;
    end
    if (addr_i[1]) begin
      s0 += C_A;
      s1 -= C_A;
      s2 -= C_A;
      s3 += C_A;
    end
    if (addr_i[0]) begin
      s0 += C_C;
      s1 -= C_B;
      s2 += C_B;
      s3 -= C_C;
    end
  end

  assign lut0_o = LW'(s0);
  assign lut1_o = LW'(s1);
  assign lut2_o = LW'(s2);
  assign lut3_o = LW'(s3);

endmodule

// File: rtl/da_idct4.sv
// Four-point 1-D inverse DCT, bit-serial distributed arithmetic, MSB first.
// One transform every DW+1 cycles; results appear as a registered one-cycle out_valid pulse.
module da_idct4 #(
  parameter int unsigned DW = 12,
  parameter int unsigned CF = da_idct_pkg::CF,
  parameter int unsigned AW = 25
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 start,
  input  logic signed [DW-1:0] Y0,
  input  logic signed [DW-1:0] Y1,
  input  logic signed [DW-1:0] Y2,
  input  logic signed [DW-1:0] Y3,
  output logic                 busy,
  output logic                 out_valid,
  output logic signed [DW-1:0] x0,
  output logic signed [DW-1:0] x1,
  output logic signed [DW-1:0] x2,
  output logic signed [DW-1:0] x3
);

  import da_idct_pkg::*;

  localparam int unsigned JW = (DW > 1) ? $clog2(DW) : 1;

  state_e                state_q, state_d;
  logic [JW-1:0]         j_q, j_d;
  logic signed [DW-1:0]  y_q   [4];
  logic signed [DW-1:0]  y_d   [4];
  logic signed [AW-1:0]  acc_q [4];
  logic signed [AW-1:0]  acc_d [4];
  logic signed [DW-1:0]  x_q   [4];
  logic signed [DW-1:0]  x_d   [4];
  logic                  valid_q, valid_d;
  logic [3:0]            addr;
  logic signed [LW-1:0]  lut   [4];

  assign addr = {y_q[0][j_q], y_q[1][j_q], y_q[2][j_q], y_q[3][j_q]};

  da_idct4_lut u_lut (
    .addr_i (addr),
    .lut0_o (lut[0]),
    .lut1_o (lut[1]),
    .lut2_o (lut[2]),
    .lut3_o (lut[3])
  );

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    y_d     = y_q;
    acc_d   = acc_q;
    x_d     = x_q;
    valid_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          y_d     = '{Y0, Y1, Y2, Y3};
          j_d     = JW'(DW - 1);
          state_d = StShift;
        end
      end
      StShift: begin
        for (int n = 0; n < 4; n++) begin
          // The sign-bit slice carries negative weight in two's complement.
          if (j_q == JW'(DW - 1)) begin
            acc_d[n] = -AW'(lut[n]);
          end else begin
            acc_d[n] = (acc_q[n] <<< 1) + AW'(lut[n]);
          end
        end
        if (j_q == '0) begin
          state_d = StDone;
        end else begin
          j_d = j_q - JW'(1);
        end
      end
      StDone: begin
        valid_d = 1'b1;
        for (int n = 0; n < 4; n++) begin
          x_d[n] = DW'(round_sat(64'(acc_q[n]), CF, DW));
        end
        if (start) begin
          y_d     = '{Y0, Y1, Y2, Y3};
          j_d     = JW'(DW - 1);
          state_d = StShift;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= StIdle;
      j_q     <= JW'(DW - 1);
      valid_q <= 1'b0;
      for (int n = 0; n < 4; n++) begin
        y_q[n]   <= '0;
        acc_q[n] <= '0;
        x_q[n]   <= '0;
      end
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      valid_q <= valid_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign out_valid = valid_q;
  assign x0        = x_q[0];
  assign x1        = x_q[1];
  assign x2        = x_q[2];
  assign x3        = x_q[3];

endmodule

// File: tb/tb_da_idct4.sv
// Directed bench for da_idct4: single vectors, back-to-back with an ignored mid-shift start,
// and reset abort.
module tb_da_idct4;

  logic               sys_clk = 1'b0;
  logic               sys_rst;
  logic               start;
  logic signed [11:0] Y0, Y1, Y2, Y3;
  logic               busy;
  logic               out_valid;
  logic signed [11:0] x0, x1, x2, x3;

  int n_total = 0;
  int n_bad   = 0;

  da_idct4 dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .start     (start),
    .Y0        (Y0),
    .Y1        (Y1),
    .Y2        (Y2),
    .Y3        (Y3),
    .busy      (busy),
    .out_valid (out_valid),
    .x0        (x0),
    .x1        (x1),
    .x2        (x2),
    .x3        (x3)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic set_y(input int a, input int b, input int c, input int d);
    Y0 = 12'(a);
    Y1 = 12'(b);
    Y2 = 12'(c);
    Y3 = 12'(d);
  endtask

  task automatic check_x(input string tag, input int e0, input int e1, input int e2,
                         input int e3);
    check({tag, " x0"}, int'(x0), e0);
    check({tag, " x1"}, int'(x1), e1);
    check({tag, " x2"}, int'(x2), e2);
    check({tag, " x3"}, int'(x3), e3);
  endtask

  // Cycle k is the cycle after edge E+k, where E samples start.
  task automatic run_vec(input string tag, input int a, input int b, input int c, input int d,
                         input int e0, input int e1, input int e2, input int e3);
    int k;
    int busy_cnt;
    bit seen;
    @(negedge sys_clk);
    set_y(a, b, c, d);
    start = 1'b1;
    @(negedge sys_clk);
    start    = 1'b0;
    k        = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    while (k < 40) begin
      if (busy) busy_cnt++;
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      k++;
      @(negedge sys_clk);
    end
    check({tag, " latency"}, seen ? k : -1, 13);
    check({tag, " busy_cycles"}, busy_cnt, 13);
    check_x(tag, e0, e1, e2, e3);
  endtask

  initial begin
    int k2;
    int vcnt;
    sys_rst = 1'b1;
    start   = 1'b0;
    set_y(0, 0, 0, 0);
    repeat (3) @(negedge sys_clk);
    check("rst busy", int'(busy), 0);
    check("rst out_valid", int'(out_valid), 0);
    check_x("rst", 0, 0, 0, 0);
    sys_rst = 1'b0;

    run_vec("dc", 1024, 0, 0, 0, 512, 512, 512, 512);
    run_vec("k1", 0, 1024, 0, 0, 669, 277, -277, -669);
    run_vec("neg_dc", -2048, 0, 0, 0, -1024, -1024, -1024, -1024);
    run_vec("sat", 2047, 2047, 0, 0, 2047, 1577, 470, -314);

    // Back-to-back: A = Y1 only, B = Y2 only, stray start mid-shift with other operands.
    @(negedge sys_clk);
    set_y(0, 1024, 0, 0);
    start = 1'b1;
    @(negedge sys_clk);
    for (int k = 0; k < 12; k++) begin
      start = (k == 5);
      if (k == 5) set_y(2047, 2047, 2047, 2047);
      @(negedge sys_clk);
    end
    check("b2b done busy", int'(busy), 1);
    check("b2b done out_valid", int'(out_valid), 0);
    set_y(0, 0, 1024, 0);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    check("b2b first valid", int'(out_valid), 1);
    check_x("b2b first", 669, 277, -277, -669);
    k2 = 0;
    do begin
      @(negedge sys_clk);
      k2++;
    end while (!out_valid && k2 < 40);
    check("b2b gap", out_valid ? k2 : -1, 13);
    check_x("b2b second", 512, -512, -512, 512);

    // Reset during shift cycle 5 aborts the transform.
    @(negedge sys_clk);
    set_y(1024, 0, 0, 0);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    repeat (5) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    check("abort busy", int'(busy), 0);
    check("abort out_valid", int'(out_valid), 0);
    check_x("abort", 0, 0, 0, 0);
    vcnt = 0;
    repeat (20) begin
      @(negedge sys_clk);
      if (out_valid) vcnt++;
    end
    check("abort no valid", vcnt, 0);
    run_vec("post_rst", 0, 0, 0, 1024, 277, -669, 669, -277);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
